// File: rtl/msft_clk_en_gen.sv
// msft_clk_en_gen
// All-digital clock-enable and divided-clock generator. It derives NUM_CH
// independent channels from sysClk_i. Each channel has a run-time
// programmable divide ratio. A new ratio takes effect only at the channel's
// period wrap, so no truncated or stretched period is ever emitted. align_i
// restarts every channel in phase. locked_o reports that the outputs have
// run undisturbed for LOCK_CYCLES edges.
//
// Ports
//   sysClk_i   : only clock
//   sysRst_i   : synchronous, active-high reset (highest priority)
//   cfgWrEn_i  : write strobe for a new divide ratio
//   cfgCh_i    : target channel; values >= NUM_CH are ignored
//   cfgDiv_i   : new divide ratio D (0 is treated as 1)
//   align_i    : restart all channels at phase 0 and apply pending ratios
//   cfgBusy_o  : per channel, a written ratio is waiting for its wrap
//   clkEn_o    : per channel, one-cycle pulse every D cycles
//   divClk_o   : per channel, registered divided clock (odd D: high longer)
//   locked_o   : outputs stable for LOCK_CYCLES edges since reset/align
//
// Handshake: there is no back-pressure. cfgWrEn_i is a single-cycle strobe
// that is always accepted. cfgBusy_o is status only. A second write to a
// busy channel simply replaces the pending ratio.

module msft_clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DIV_RESET   = 4,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sysClk_i,
  input  logic              sysRst_i,
  input  logic              cfgWrEn_i,
  input  logic [CH_W-1:0]   cfgCh_i,
  input  logic [DIV_W-1:0]  cfgDiv_i,
  input  logic              align_i,
  output logic [NUM_CH-1:0] cfgBusy_o,
  output logic [NUM_CH-1:0] clkEn_o,
  output logic [NUM_CH-1:0] divClk_o,
  output logic              locked_o
);

  localparam int               LCNT_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_RESET);
  localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(LOCK_CYCLES);

  logic [DIV_W-1:0]  wr_div;
  logic [NUM_CH-1:0] wr_hit;

  // Decode the write once for all channels; a ratio of 0 behaves as 1.
  always_comb begin
    wr_div = (cfgDiv_i == '0) ? DIV_W'(1) : cfgDiv_i;
    wr_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = cfgWrEn_i && (cfgCh_i == CH_W'(c));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] d_cur;
    logic [DIV_W-1:0] d_pend;
    logic [DIV_W-1:0] ph;
    logic             pend;
    logic             en_q;
    logic             dc_q;
    logic [DIV_W:0]   half;
    logic             wrap;

    // High time is ceil(D/2) so odd ratios are high one cycle longer.
    assign half = ({1'b0, d_cur} + (DIV_W+1)'(1)) >> 1;
    assign wrap = (ph == d_cur - DIV_W'(1));

    always_ff @(posedge sysClk_i) begin
      if (sysRst_i) begin
        d_cur  <= DIV_RST;
        d_pend <= DIV_RST;
        ph     <= '0;
        pend   <= 1'b0;
        en_q   <= 1'b0;
        dc_q   <= 1'b0;
      end else if (align_i) begin
        // A write on the align edge beats an older pending ratio.
        ph   <= '0;
        pend <= 1'b0;
        en_q <= 1'b0;
        dc_q <= 1'b0;
        if (wr_hit[g]) begin
          d_cur <= wr_div;
        end else if (pend) begin
          d_cur <= d_pend;
        end
      end else begin
        en_q <= (ph == '0);
        dc_q <= ({1'b0, ph} < half);
        if (wrap) begin
          ph <= '0;
          if (pend) begin
            d_cur <= d_pend;
            pend  <= 1'b0;
          end
        end else begin
          ph <= ph + DIV_W'(1);
        end
        // Placed after the wrap handling so a write on the wrap edge stays
        // pending for the following wrap instead of being bypassed.
        if (wr_hit[g]) begin
          d_pend <= wr_div;
          pend   <= 1'b1;
        end
      end
    end

    assign cfgBusy_o[g] = pend;
    assign clkEn_o[g]   = en_q;
    assign divClk_o[g]  = dc_q;
  end

  logic [LCNT_W-1:0] lock_cnt;
  logic              locked_q;

  // Saturating settle counter; ratio writes deliberately do not touch it.
  always_ff @(posedge sysClk_i) begin
    if (sysRst_i || align_i) begin
      lock_cnt <= '0;
      locked_q <= 1'b0;
    end else if (lock_cnt != LOCK_MAX) begin
      lock_cnt <= lock_cnt + LCNT_W'(1);
      locked_q <= (lock_cnt == LOCK_MAX - LCNT_W'(1));
    end
  end

  assign locked_o = locked_q;

endmodule

// File: tb/tb_msft_clk_en_gen.sv
// Testbench for msft_clk_en_gen (NUM_CH=4, DIV_RESET=4, LOCK_CYCLES=16).
// CH_W is widened to 3 so that an out-of-range channel number can be driven.
module tb_msft_clk_en_gen;

  localparam int NCH  = 4;
  localparam int LOCK = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic       align = 1'b0;
  logic [2:0] ch = '0;
  logic [7:0] div = '0;
  logic [3:0] busy, clken, divclk;
  logic       locked;

  always #5 clk = ~clk;

  msft_clk_en_gen #(
    .NUM_CH(NCH), .DIV_W(8), .DIV_RESET(4), .LOCK_CYCLES(LOCK), .CH_W(3)
  ) dut (
    .sysClk_i(clk), .sysRst_i(rst), .cfgWrEn_i(wr), .cfgCh_i(ch),
    .cfgDiv_i(div), .align_i(align), .cfgBusy_o(busy), .clkEn_o(clken),
    .divClk_o(divclk), .locked_o(locked)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [12:0] exp_q[$];

  int   m_dcur[NCH], m_dpend[NCH], m_ph[NCH];
  bit   m_pend[NCH];
  logic [3:0] m_en, m_dv;
  bit   m_lk;
  int   m_lcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge, from the pre-edge state and inputs.
  task automatic model_edge();
    logic [3:0] pv;
    int nd;
    bit hit;
    nd = (div == 0) ? 1 : int'(div);
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_dcur[c] = 4; m_dpend[c] = 4; m_ph[c] = 0; m_pend[c] = 0;
      end
      m_en = '0; m_dv = '0; m_lcnt = 0; m_lk = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        hit = wr && (int'(ch) == c);
        if (align) begin
          m_ph[c] = 0;
          if (hit) m_dcur[c] = nd;
          else if (m_pend[c]) m_dcur[c] = m_dpend[c];
          m_pend[c] = 0;
          m_en[c] = 0;
          m_dv[c] = 0;
        end else begin
          m_en[c] = (m_ph[c] == 0);
          m_dv[c] = (m_ph[c] < (m_dcur[c] + 1) / 2);
          if (m_ph[c] == m_dcur[c] - 1) begin
            m_ph[c] = 0;
            if (m_pend[c]) begin
              m_dcur[c] = m_dpend[c];
              m_pend[c] = 0;
            end
          end else begin
            m_ph[c]++;
          end
          if (hit) begin
            m_dpend[c] = nd;
            m_pend[c] = 1;
          end
        end
      end
      if (align) begin
        m_lcnt = 0; m_lk = 0;
      end else if (m_lcnt < LOCK) begin
        m_lcnt++;
        m_lk = (m_lcnt == LOCK);
      end
    end
    for (int c = 0; c < NCH; c++) pv[c] = m_pend[c];
    exp_q.push_back({m_lk, pv, m_dv, m_en});
  endtask

  // ---------------- driver ----------------
  task automatic step();
    logic [12:0] e;
    model_edge();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk("cycle", {locked, busy, divclk, clken}, e);
    end
    wr = 1'b0;
    align = 1'b0;
  endtask

  task automatic write(input int c, input int d);
    wr = 1'b1;
    ch = 3'(c);
    div = 8'(d);
  endtask

  function automatic logic [3:0] en_pat(input int a, input int d0, input int d1,
                                        input int d2, input int d3);
    en_pat = {((a - 1) % d3) == 0, ((a - 1) % d2) == 0,
              ((a - 1) % d1) == 0, ((a - 1) % d0) == 0};
  endfunction

  function automatic logic [3:0] dv_pat(input int a, input int d0, input int d1,
                                        input int d2, input int d3);
    dv_pat = {((a - 1) % d3) < (d3 + 1) / 2, ((a - 1) % d2) < (d2 + 1) / 2,
              ((a - 1) % d1) < (d1 + 1) / 2, ((a - 1) % d0) < (d0 + 1) / 2};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int n;

    // Reset default
    rst = 1'b1;
    repeat (3) step();
    chk("rst_outputs", {locked, busy, divclk, clken}, 13'h0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("rst_en_pattern", clken, en_pat(k, 4, 4, 4, 4));
      chk("rst_dv_pattern", divclk, dv_pat(k, 4, 4, 4, 4));
      if (k == 15) chk("lock_edge15", locked, 1'b0);
      if (k == 16) chk("lock_edge16", locked, 1'b1);
    end

    // Odd ratio on ch1, D=0 (treated as 1) on ch2
    for (int k = 17; k <= 26; k++) begin
      if (k == 17) write(1, 3);
      if (k == 18) write(2, 0);
      step();
      if (k <= 19) chk("ch1_busy", busy[1], 1'b1);
      if (k == 20) chk("ch1_busy_clr", busy[1], 1'b0);
      if (k >= 21) begin
        chk("ch1_en_d3", clken[1], ((k - 21) % 3) == 0);
        chk("ch1_dv_d3", divclk[1], ((k - 21) % 3) < 2);
        chk("ch2_en_d1", clken[2], 1'b1);
        chk("ch2_dv_d1", divclk[2], 1'b1);
      end
    end

    // Glitch-free reprogram of ch0 from 4 to 6
    for (int k = 27; k <= 40; k++) begin
      if (k == 29) write(0, 6);
      step();
      if (k >= 29 && k <= 31) chk("ch0_busy", busy[0], 1'b1);
      if (k == 32) chk("ch0_busy_clr", busy[0], 1'b0);
      if (k >= 29) chk("ch0_en_4to6", clken[0], (k == 29) || (k == 33) || (k == 39));
    end

    // Overwrite before the wrap, then a write on the wrap edge
    for (int k = 41; k <= 62; k++) begin
      if (k == 41) write(3, 5);
      if (k == 42) write(3, 7);
      if (k == 51) write(3, 2);
      step();
      if (k == 44) chk("ch3_busy_clr", busy[3], 1'b0);
      if (k == 51 || k == 57) chk("ch3_busy_coll", busy[3], 1'b1);
      if (k == 58) chk("ch3_busy_coll_clr", busy[3], 1'b0);
      if (k >= 45) chk("ch3_en_7then2", clken[3],
                       (k == 45) || (k == 52) || (k == 59) || (k == 61));
    end

    // Align with ratios 3,4,5,6 at arbitrary phases
    write(0, 3);
    step();
    write(1, 4);
    step();
    n = $urandom_range(8, 20);
    repeat (n) step();
    write(2, 5);        // still pending when align arrives
    step();
    align = 1'b1;
    write(3, 6);        // same-edge write, applied immediately
    step();
    chk("align_en0", clken, 4'h0);
    chk("align_dv0", divclk, 4'h0);
    chk("align_busy0", busy, 4'h0);
    chk("align_unlock", locked, 1'b0);
    for (int a = 1; a <= 30; a++) begin
      step();
      chk("align_en_pattern", clken, en_pat(a, 3, 4, 5, 6));
      chk("align_dv_pattern", divclk, dv_pat(a, 3, 4, 5, 6));
      if (a == 15) chk("align_lock15", locked, 1'b0);
      if (a == 16) chk("align_lock16", locked, 1'b1);
    end

    // Reset mid-operation, then a write to a non-existent channel
    n = $urandom_range(1, 7);
    repeat (n) step();
    write(1, 7);
    step();
    rst = 1'b1;
    step();
    chk("midrst_outputs", {locked, busy, divclk, clken}, 13'h0);
    rst = 1'b0;
    for (int a = 1; a <= 16; a++) begin
      if (a == 3) write(4, 9);
      step();
      chk("midrst_en_pattern", clken, en_pat(a, 4, 4, 4, 4));
      chk("midrst_dv_pattern", divclk, dv_pat(a, 4, 4, 4, 4));
      chk("badch_busy", busy, 4'h0);
      if (a == 16) chk("midrst_lock16", locked, 1'b1);
    end

    // Free run with random ratio writes against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) write($urandom_range(0, 4), $urandom_range(0, 9));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msft_clk_en_gen.md
# msft_clk_en_gen

Parametrised, all-digital clock-enable and divided-clock generator for the Arty7 platform. It derives NUM_CH independent divided clocks and clock enables from sysClk_i. Each channel has its own divide ratio, reprogrammable at run time without glitches, and all channels can be re-phased together. A lock indication tells downstream logic when the outputs are stable. It sits next to the board MMCM wrapper and supplies slow peripheral clock domains (UART, SPI, timers) where an extra MMCM output is wasteful or unavailable in Verilator.

## Interface
- NUM_CH, 4: number of output channels, 1..16.
- DIV_W, 8: divide-ratio width.
- DIV_RESET, 4: divide ratio loaded into every channel at reset, 1..2^DIV_W-1.
- LOCK_CYCLES, 16: settle count before locked_o rises, at least 1.
- CH_W, max(1, clog2(NUM_CH)): channel-select width (derived).

- sysClk_i  in  1  only clock.
- sysRst_i  in  1  reset; synchronous, active-high.
- cfgWrEn_i  in  1  write a new divide ratio this cycle.
- cfgCh_i  in  CH_W  target channel; values ≥ NUM_CH are ignored.
- cfgDiv_i  in  DIV_W  new divide ratio D; 0 is treated as 1.
- align_i  in  1  restart all channels in phase.
- cfgBusy_o  out  NUM_CH  per channel: a written ratio is pending.
- clkEn_o  out  NUM_CH  one-cycle enable pulse, once per D cycles.
- divClk_o  out  NUM_CH  registered divided clock.
- locked_o  out  1  outputs stable since the last reset or align.

## Operation
- Per-channel state:
  - current ratio Dcur (DIV_W bits);
  - pending ratio Dpend and a pending flag;
  - phase counter ph, 0..Dcur-1.
- Output decode, all outputs are flops. On each non-reset, non-align edge, per channel:
  - clkEn_o is set to (ph==0);
  - divClk_o is set to (ph < ceil(Dcur/2));
  - ph advances to (ph==Dcur-1) ? 0 : ph+1.
- Duty cycle:
  - even D gives 50%;
  - odd D is high one cycle longer than low;
  - D=1 gives clkEn_o=1 every cycle and divClk_o held at 1.
- Write handling:
  - cfgWrEn_i with a valid cfgCh_i stores max(cfgDiv_i,1) in Dpend and sets the pending flag.
  - cfgBusy_o reflects the pending flag from the next cycle.
  - A write while pending overwrites Dpend; the last write wins.
- Apply at wrap:
  - At the edge where ph wraps (ph==Dcur-1), a pending Dpend moves into Dcur and the flag clears.
  - The new ratio governs from the following phase 0, so no truncated or stretched period is ever emitted.
  - A write on the same edge as a wrap is not bypassed; it is applied at the next wrap.
- Align: align_i sampled high, for all channels:
  - ph goes to 0;
  - any pending ratio is applied immediately;
  - a write on the same edge is applied immediately;
  - all busy flags clear;
  - clkEn_o and divClk_o are forced to 0;
  - the lock counter restarts.
- Lock:
  - A saturating counter is cleared by reset or align.
  - locked_o is set on the LOCK_CYCLES-th rising edge after the last edge that sampled sysRst_i or align_i high.
  - Ratio writes do not affect locked_o.
- Reset (sysRst_i high) takes priority over everything:
  - Dcur = DIV_RESET, ph = 0, pending cleared;
  - clkEn_o = 0, divClk_o = 0, cfgBusy_o = 0, locked_o = 0.

## Timing
- Ratio writes take effect after wrap-and-apply, as above; there is no separate write latency.
- Latency from reset or align:
  - The first edge with sysRst_i and align_i low sets clkEn_o=1 and divClk_o=1 on every channel (D=1 included).
  - Channels with equal D remain exactly in phase.
- Write to apply latency: 1 to Dcur cycles, depending on the current phase.
- Period: clkEn_o pulses are exactly Dcur cycles apart. The transition period after an apply is Dold followed by Dnew, with no partial period.
- There is no handshake back-pressure; cfgBusy_o is informational.
- Lock count: locked_o=1 exactly LOCK_CYCLES edges after reset or align deassertion.
- Reset or align mid-period: the period is aborted immediately and outputs go to 0 on that edge, with no glitch pulses.

## Test plan
- **Reset default.** NUM_CH=4, DIV_RESET=4.
  - Release reset → clkEn_o=4'hF on the first edge, then every 4 cycles.
  - divClk_o runs 2 high / 2 low.
  - locked_o rises on edge 16.
- **Odd ratio and D=1.**
  - Write ch1=3 → after the wrap, divClk_o[1] runs 2 high / 1 low.
  - Write ch2=0 → clkEn_o[2]=1 every cycle and divClk_o[2] stays 1.
- **Glitch-free reprogram.**
  - With ch0 at D=4 and ph=1, write D=6 → cfgBusy_o[0]=1 for 3 cycles.
  - The last 4-cycle period completes, then the next clkEn_o[0] is 6 cycles later.
- **Overwrite and edge collision.**
  - Write ch3=5 then ch3=7 before the wrap → 7 is applied.
  - A write on the wrap edge is applied one period later.
- **Align.**
  - Channels at D=3,4,5,6 at random phases; pulse align_i → all outputs 0 that cycle and all clkEn_o=1 the next.
  - locked_o drops and then rises again after 16 edges.
- **Reset mid-operation and invalid channel.**
  - Assert sysRst_i mid-period → all outputs 0 and ratios restored to 4.
  - A write with cfgCh_i=4 when NUM_CH=4 leaves every channel unchanged.
